rf_wb_arbiter: RTL and testbench

Writeback arbiter and sequencer for the single write port of the 32×32 register file. Two writeback sources share that port through per-source FIFOs and a registered output stage: source 0 is the ALU/execute path and source 1 is the load/multicycle path. The arbiter guarantees that writes to the same register commit in acceptance order, prevents starvation of source 1, and exports a pending-write mask for the hazard/stall logic.

---
 rtl/rf_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: two per-source FIFOs,
// same-register ordering through the ready rules, a starvation guard for source 1, and a pending mask.
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s0_valid,
    output logic                              s0_ready,
    input  logic [4:0]                        s0_rd,
    input  logic [31:0]                       s0_data,
    input  logic                              s1_valid,
    output logic                              s1_ready,
    input  logic [4:0]                        s1_rd,
    input  logic [31:0]                       s1_data,
    output logic                              rf_we,
    output logic [4:0]                        rf_rd,
    output logic [31:0]                       rf_wdata,
    output logic [31:0]                       pending,
    output logic [$clog2(STARVE_MAX+1)-1:0]   o_dbg_starve
);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            SW       = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]    r_fifo_rd   [2][DEPTH];
    logic [31:0]   r_fifo_data [2][DEPTH];
    logic [CW-1:0] r_cnt       [2];
    logic [SW-1:0] r_starve;
    logic          r_we;
    logic [4:0]    r_rd;
    logic [31:0]   r_wdata;

    logic          w_s0_hit_f1;
    logic          w_s1_hit_f0;
    logic          w_s1_hit_s0;
    logic          w_head0;
    logic          w_head1;
    logic          w_sel1;
    logic          w_push    [2];
    logic          w_pop     [2];
    logic [4:0]    w_in_rd   [2];
    logic [31:0]   w_in_data [2];
    logic [CW-1:0] w_wr_idx  [2];
    logic [31:0]   w_pending;

    // Handshake: a source transfers on a rising edge where valid and ready are both 1; ready
    // never looks at valid of its own source and ignores any pop happening in the same cycle.
    always_comb begin
        w_s0_hit_f1 = 1'b0;
        w_s1_hit_f0 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(r_cnt[1])) && (r_fifo_rd[1][i] == s0_rd)) w_s0_hit_f1 = 1'b1;
            if ((i < int'(r_cnt[0])) && (r_fifo_rd[0][i] == s1_rd)) w_s1_hit_f0 = 1'b1;
        end
    end

    assign w_s1_hit_s0 = s0_valid && (s0_rd == s1_rd);
    assign s0_ready    = rst_n && (r_cnt[0] < DEPTH_C) && !((s0_rd != 5'd0) && w_s0_hit_f1);
    assign s1_ready    = rst_n && (r_cnt[1] < DEPTH_C) &&
                         !((s1_rd != 5'd0) && (w_s1_hit_f0 || w_s1_hit_s0));

    assign w_head0 = (r_cnt[0] != '0);
    assign w_head1 = (r_cnt[1] != '0);
    assign w_sel1  = w_head1 && ((r_starve == STARVE_C) || !w_head0);

    // Writes to x0 complete the handshake but never enter a FIFO.
    always_comb begin
        w_push[0]    = s0_valid && s0_ready && (s0_rd != 5'd0);
        w_push[1]    = s1_valid && s1_ready && (s1_rd != 5'd0);
        w_pop[0]     = w_head0 && !w_sel1;
        w_pop[1]     = w_sel1;
        w_in_rd[0]   = s0_rd;
        w_in_rd[1]   = s1_rd;
        w_in_data[0] = s0_data;
        w_in_data[1] = s1_data;
        for (int s = 0; s < 2; s++) begin
            w_wr_idx[s] = r_cnt[s] - CW'(w_pop[s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                r_cnt[s] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_fifo_rd[s][i]   <= '0;
                    r_fifo_data[s][i] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_pop[s]) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        r_fifo_rd[s][i]   <= r_fifo_rd[s][i+1];
                        r_fifo_data[s][i] <= r_fifo_data[s][i+1];
                    end
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_push[s] && (i == int'(w_wr_idx[s]))) begin
                        r_fifo_rd[s][i]   <= w_in_rd[s];
                        r_fifo_data[s][i] <= w_in_data[s];
                    end
                end
                r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_pop[1]) begin
                r_starve <= '0;
            end else if (w_head1 && (r_starve != STARVE_C)) begin
                r_starve <= r_starve + SW'(1);
            end
            r_we <= w_pop[0] || w_pop[1];
            if (w_pop[1]) begin
                r_rd    <= r_fifo_rd[1][0];
                r_wdata <= r_fifo_data[1][0];
            end else if (w_pop[0]) begin
                r_rd    <= r_fifo_rd[0][0];
                r_wdata <= r_fifo_data[0][0];
            end
        end
    end

    // Staged write still counts as pending until the register file takes it.
    always_comb begin
        w_pending = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i < int'(r_cnt[s])) w_pending[r_fifo_rd[s][i]] = 1'b1;
            end
        end
        if (r_we) w_pending[r_rd] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign rf_we        = r_we;
    assign rf_rd        = r_rd;
    assign rf_wdata     = r_wdata;
    assign pending      = w_pending;
    assign o_dbg_starve = r_starve;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with fixed expectations, then random traffic
// checked cycle by cycle against a queue-based model of the writeback rules.
module tb_rf_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [4:0]  s0_rd, s1_rd, rf_rd;
    logic [31:0] s0_data, s1_data, rf_wdata, pending;
    logic        rf_we;
    logic [2:0]  o_dbg_starve;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] dut_regs [32];
    logic [31:0] m_regs   [32];
    logic [31:0] exp_q[$];

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pending(pending),
        .o_dbg_starve(o_dbg_starve)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s0_valid = 1'($urandom_range(0, 1)); s0_rd = 5'($urandom_range(0, 31)); s0_data = $urandom;
            s1_valid = 1'($urandom_range(0, 1)); s1_rd = 5'($urandom_range(0, 31)); s1_data = $urandom;
            tick;
            checks++; if (rf_we !== 1'b0) begin $display("FAIL reset_we: got %0b want 0", rf_we); errors++; end
            checks++; if (rf_rd !== 5'd0) begin $display("FAIL reset_rd: got %0d want 0", rf_rd); errors++; end
            checks++; if (rf_wdata !== 32'd0) begin $display("FAIL reset_wdata: got %h want 0", rf_wdata); errors++; end
            checks++; if (pending !== 32'd0) begin $display("FAIL reset_pending: got %h want 0", pending); errors++; end
            checks++; if (s0_ready !== 1'b0) begin $display("FAIL reset_s0_ready: got %0b want 0", s0_ready); errors++; end
            checks++; if (s1_ready !== 1'b0) begin $display("FAIL reset_s1_ready: got %0b want 0", s1_ready); errors++; end
        end
        drive_idle;
        rst_n = 1'b1;
        #1;
        checks++; if (s0_ready !== 1'b1) begin $display("FAIL release_s0_ready: got %0b want 1", s0_ready); errors++; end
        checks++; if (s1_ready !== 1'b1) begin $display("FAIL release_s1_ready: got %0b want 1", s1_ready); errors++; end
        checks++; if (o_dbg_starve !== 3'd0) begin $display("FAIL release_starve: got %0d want 0", o_dbg_starve); errors++; end
    endtask

    task automatic test_single_write;
        s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'hDEADBEEF; s1_valid = 1'b0;
        #1;
        checks++; if (s0_ready !== 1'b1) begin $display("FAIL single_ready: got %0b want 1", s0_ready); errors++; end
        tick;
        s0_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) begin $display("FAIL single_we_c0: got %0b want 0", rf_we); errors++; end
        checks++; if (pending !== 32'h20) begin $display("FAIL single_pend_c0: got %h want 00000020", pending); errors++; end
        tick;
        checks++; if (rf_we !== 1'b1) begin $display("FAIL single_we_c1: got %0b want 1", rf_we); errors++; end
        checks++; if (rf_rd !== 5'd5) begin $display("FAIL single_rd: got %0d want 5", rf_rd); errors++; end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); errors++; end
        checks++; if (pending !== 32'h20) begin $display("FAIL single_pend_c1: got %h want 00000020", pending); errors++; end
        if (rf_we) dut_regs[rf_rd] = rf_wdata;
        tick;
        checks++; if (rf_we !== 1'b0) begin $display("FAIL single_we_c2: got %0b want 0", rf_we); errors++; end
        checks++; if (pending !== 32'h0) begin $display("FAIL single_pend_c2: got %h want 0", pending); errors++; end
        checks++; if (dut_regs[5] !== 32'hDEADBEEF) begin $display("FAIL single_reg5: got %h want deadbeef", dut_regs[5]); errors++; end
    endtask

    task automatic test_simultaneous;
        s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'h11;
        s1_valid = 1'b1; s1_rd = 5'd4; s1_data = 32'h22;
        #1;
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            $display("FAIL simul_ready: got %0b/%0b want 1/1", s0_ready, s1_ready); errors++; end
        tick;
        drive_idle;
        checks++; if (pending !== 32'h18) begin $display("FAIL simul_pend_c0: got %h want 00000018", pending); errors++; end
        tick;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h11) begin
            $display("FAIL simul_first: got we=%0b rd=%0d data=%h want 1/3/11", rf_we, rf_rd, rf_wdata); errors++; end
        checks++; if (o_dbg_starve !== 3'd1) begin $display("FAIL simul_starve1: got %0d want 1", o_dbg_starve); errors++; end
        tick;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h22) begin
            $display("FAIL simul_second: got we=%0b rd=%0d data=%h want 1/4/22", rf_we, rf_rd, rf_wdata); errors++; end
        checks++; if (o_dbg_starve !== 3'd0) begin $display("FAIL simul_starve0: got %0d want 0", o_dbg_starve); errors++; end
        tick;
        checks++; if (rf_we !== 1'b0 || pending !== 32'h0) begin
            $display("FAIL simul_idle: got we=%0b pend=%h want 0/0", rf_we, pending); errors++; end
    endtask

    task automatic test_starvation;
        logic [4:0] exp_rd;
        for (int k = 0; k < 6; k++) begin
            s0_valid = 1'b1; s0_rd = 5'(10 + k); s0_data = 32'(32'h100 + k);
            s1_valid = (k == 0); s1_rd = 5'd9; s1_data = 32'h99;
            #1;
            checks++; if (s0_ready !== 1'b1) begin $display("FAIL starve_s0_ready k=%0d: got %0b want 1", k, s0_ready); errors++; end
            tick;
            if (k >= 1) begin
                exp_rd = (k == 5) ? 5'd9 : 5'(9 + k);
                checks++; if (rf_we !== 1'b1 || rf_rd !== exp_rd) begin
                    $display("FAIL starve_sel k=%0d: got we=%0b rd=%0d want 1/%0d", k, rf_we, rf_rd, exp_rd); errors++; end
                checks++; if (o_dbg_starve !== ((k == 5) ? 3'd0 : 3'(k))) begin
                    $display("FAIL starve_cnt k=%0d: got %0d", k, o_dbg_starve); errors++; end
            end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        checks++; if (s0_ready !== 1'b0) begin $display("FAIL starve_full_ready: got %0b want 0", s0_ready); errors++; end
        tick;
        checks++; if (rf_rd !== 5'd14 || rf_wdata !== 32'h104) begin
            $display("FAIL starve_drain1: got rd=%0d data=%h want 14/104", rf_rd, rf_wdata); errors++; end
        tick;
        checks++; if (rf_rd !== 5'd15 || rf_wdata !== 32'h105) begin
            $display("FAIL starve_drain2: got rd=%0d data=%h want 15/105", rf_rd, rf_wdata); errors++; end
        tick;
        checks++; if (rf_we !== 1'b0) begin $display("FAIL starve_idle: got %0b want 0", rf_we); errors++; end
        drive_idle;
    endtask

    task automatic test_same_rd;
        logic        acc;
        logic [31:0] exp;
        exp_q.delete();
        exp_q.push_back(32'hA);
        exp_q.push_back(32'hB);
        s0_valid = 1'b1; s0_rd = 5'd7; s0_data = 32'hA;
        s1_valid = 1'b1; s1_rd = 5'd7; s1_data = 32'hB;
        #1;
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            $display("FAIL same_ready_c: got %0b/%0b want 1/0", s0_ready, s1_ready); errors++; end
        tick;
        s0_valid = 1'b0;
        #1;
        checks++; if (s1_ready !== 1'b0) begin $display("FAIL same_s1_blocked: got %0b want 0", s1_ready); errors++; end
        for (int c = 0; c < 8; c++) begin
            acc = s1_valid && s1_ready;
            tick;
            if (acc) s1_valid = 1'b0;
            if (rf_we && rf_rd == 5'd7) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL same_extra_commit: got %h want none", rf_wdata); errors++;
                end else begin
                    exp = exp_q.pop_front();
                    if (rf_wdata !== exp) begin $display("FAIL same_order: got %h want %h", rf_wdata, exp); errors++; end
                end
                dut_regs[7] = rf_wdata;
            end
            #1;
        end
        checks++; if (exp_q.size() != 0) begin $display("FAIL same_missing: got %0d left want 0", exp_q.size()); errors++; end
        checks++; if (dut_regs[7] !== 32'hB) begin $display("FAIL same_final: got %h want 0000000b", dut_regs[7]); errors++; end
        drive_idle;
    endtask

    task automatic test_x0_full;
        s1_valid = 1'b1; s1_rd = 5'd0; s1_data = 32'hFFFF;
        #1;
        checks++; if (s1_ready !== 1'b1) begin $display("FAIL x0_ready: got %0b want 1", s1_ready); errors++; end
        tick;
        s1_valid = 1'b0;
        checks++; if (pending !== 32'h0 || rf_we !== 1'b0) begin
            $display("FAIL x0_c0: got pend=%h we=%0b want 0/0", pending, rf_we); errors++; end
        tick;
        checks++; if (pending !== 32'h0 || rf_we !== 1'b0) begin
            $display("FAIL x0_c1: got pend=%h we=%0b want 0/0", pending, rf_we); errors++; end
        for (int k = 0; k < 6; k++) begin
            s0_valid = 1'b1; s0_rd = 5'(10 + k); s0_data = 32'(k);
            s1_valid = 1'b1; s1_rd = (k == 0) ? 5'd20 : ((k == 1) ? 5'd21 : 5'd22); s1_data = 32'(32'h200 + k);
            #1;
            checks++; if (s1_ready !== (k <= 1)) begin
                $display("FAIL full_s1_ready k=%0d: got %0b want %0b", k, s1_ready, (k <= 1)); errors++; end
            tick;
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        checks++; if (s1_ready !== 1'b1) begin $display("FAIL full_after_pop: got %0b want 1", s1_ready); errors++; end
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd20 || rf_wdata !== 32'h200) begin
            $display("FAIL full_s1_win: got we=%0b rd=%0d data=%h want 1/20/200", rf_we, rf_rd, rf_wdata); errors++; end
        drive_idle;
        for (int c = 0; c < 6; c++) tick;
        s0_valid = 1'b1; s0_rd = 5'd1; s0_data = 32'h1111;
        s1_valid = 1'b1; s1_rd = 5'd2; s1_data = 32'h2222;
        tick;
        drive_idle;
        tick;
        checks++; if (rf_we !== 1'b1 || pending !== 32'h6) begin
            $display("FAIL midrst_pre: got we=%0b pend=%h want 1/00000006", rf_we, pending); errors++; end
        rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || pending !== 32'h0) begin
            $display("FAIL midrst_clear: got we=%0b pend=%h want 0/0", rf_we, pending); errors++; end
        checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            $display("FAIL midrst_ready: got %0b/%0b want 0/0", s0_ready, s1_ready); errors++; end
        tick;
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (rf_we !== 1'b0 || pending !== 32'h0) begin
                $display("FAIL midrst_after c=%0d: got we=%0b pend=%h want 0/0", c, rf_we, pending); errors++; end
        end
    endtask

    task automatic test_random;
        ent_t        m_q0[$];
        ent_t        m_q1[$];
        ent_t        e;
        int          m_starve;
        logic        m_we;
        logic [4:0]  m_rd;
        logic [31:0] m_wdata;
        logic        e0r, e1r, h0, h1, sel1;
        logic [31:0] epend;
        drive_idle;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        m_starve = 0; m_we = 1'b0; m_rd = '0; m_wdata = '0;
        for (int r = 0; r < 32; r++) begin dut_regs[r] = '0; m_regs[r] = '0; end
        for (int cyc = 0; cyc < 2100; cyc++) begin
            if (cyc < 2000) begin
                s0_valid = ($urandom_range(0, 9) < 7);
                s0_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                s0_data  = $urandom;
                s1_valid = ($urandom_range(0, 9) < 6);
                s1_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                s1_data  = $urandom;
            end else begin
                drive_idle;
            end
            #1;
            e0r = (m_q0.size() < DEPTH);
            if (s0_rd != 5'd0) foreach (m_q1[j]) if (m_q1[j].rd == s0_rd) e0r = 1'b0;
            e1r = (m_q1.size() < DEPTH);
            if (s1_rd != 5'd0) begin
                foreach (m_q0[j]) if (m_q0[j].rd == s1_rd) e1r = 1'b0;
                if (s0_valid && s0_rd == s1_rd) e1r = 1'b0;
            end
            epend = '0;
            foreach (m_q0[j]) epend[m_q0[j].rd] = 1'b1;
            foreach (m_q1[j]) epend[m_q1[j].rd] = 1'b1;
            if (m_we) epend[m_rd] = 1'b1;
            epend[0] = 1'b0;
            checks++; if (s0_ready !== e0r) begin $display("FAIL rnd_s0_ready cyc=%0d: got %0b want %0b", cyc, s0_ready, e0r); errors++; end
            checks++; if (s1_ready !== e1r) begin $display("FAIL rnd_s1_ready cyc=%0d: got %0b want %0b", cyc, s1_ready, e1r); errors++; end
            checks++; if (rf_we !== m_we) begin $display("FAIL rnd_we cyc=%0d: got %0b want %0b", cyc, rf_we, m_we); errors++; end
            checks++; if (rf_rd !== m_rd || rf_wdata !== m_wdata) begin
                $display("FAIL rnd_out cyc=%0d: got %0d/%h want %0d/%h", cyc, rf_rd, rf_wdata, m_rd, m_wdata); errors++; end
            checks++; if (pending !== epend) begin $display("FAIL rnd_pending cyc=%0d: got %h want %h", cyc, pending, epend); errors++; end
            checks++; if (o_dbg_starve !== 3'(m_starve)) begin
                $display("FAIL rnd_starve cyc=%0d: got %0d want %0d", cyc, o_dbg_starve, m_starve); errors++; end
            if (rf_we) dut_regs[rf_rd] = rf_wdata;
            if (m_we) m_regs[m_rd] = m_wdata;
            h0 = (m_q0.size() > 0);
            h1 = (m_q1.size() > 0);
            sel1 = h1 && (m_starve == STARVE_MAX || !h0);
            if (sel1) begin
                e = m_q1.pop_front();
                m_we = 1'b1; m_rd = e.rd; m_wdata = e.data; m_starve = 0;
            end else if (h0) begin
                e = m_q0.pop_front();
                m_we = 1'b1; m_rd = e.rd; m_wdata = e.data;
                if (h1 && m_starve < STARVE_MAX) m_starve++;
            end else begin
                m_we = 1'b0;
            end
            if (s0_valid && e0r && s0_rd != 5'd0) begin e.rd = s0_rd; e.data = s0_data; m_q0.push_back(e); end
            if (s1_valid && e1r && s1_rd != 5'd0) begin e.rd = s1_rd; e.data = s1_data; m_q1.push_back(e); end
            tick;
        end
        for (int r = 1; r < 32; r++) begin
            checks++; if (dut_regs[r] !== m_regs[r]) begin
                $display("FAIL rnd_regfile x%0d: got %h want %h", r, dut_regs[r], m_regs[r]); errors++; end
        end
    endtask

    initial begin
        drive_idle;
        for (int r = 0; r < 32; r++) dut_regs[r] = '0;
        test_reset;
        test_single_write;
        test_simultaneous;
        test_starvation;
        test_same_rd;
        test_x0_full;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
